// File: rtl/alu_issue.sv
// ID->EX issue stage: decodes a MIPS instruction into ALU controls and operands and
// holds them in a one-entry valid/ready register. Optional macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue #(
    parameter int DATA_W           = 32,
    parameter bit ZERO_DEST_SQUASH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        alu_fun,
    output logic              alu_sign,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        dest,
    output logic              wr_en,
    output logic              illegal
);
    localparam logic [5:0] FUN_ADD = 6'b000000, FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000, FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_XOR = 6'b010110, FUN_NOR = 6'b010001;
    localparam logic [5:0] FUN_SLL = 6'b100000, FUN_SRL = 6'b100001, FUN_SRA = 6'b100011;
    localparam logic [5:0] FUN_EQ  = 6'b110011, FUN_NEQ = 6'b110001, FUN_LT  = 6'b110101;
    localparam logic [5:0] FUN_LEZ = 6'b111101, FUN_LTZ = 6'b111011, FUN_GTZ = 6'b111111;

    logic [5:0]        w_op, w_funct, w_fun;
    logic [4:0]        w_rt, w_rd, w_dest;
    logic [DATA_W-1:0] w_imm_sx, w_imm_zx, w_shamt, w_a, w_b;
    logic              w_sign, w_wr, w_ill, w_accept;

    logic              r_valid;
    logic [5:0]        r_fun;
    logic              r_sign, r_wr;
    logic [DATA_W-1:0] r_a, r_b;
    logic [4:0]        r_dest;

    assign w_op     = instr[31:26];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_funct  = instr[5:0];
    assign w_imm_sx = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign w_imm_zx = {{(DATA_W-16){1'b0}}, instr[15:0]};
    assign w_shamt  = {{(DATA_W-5){1'b0}}, instr[10:6]};

    always_comb begin
        w_fun  = FUN_ADD;
        w_sign = 1'b0;
        w_a    = rs_data;
        w_b    = rt_data;
        w_dest = w_rt;
        w_wr   = 1'b1;
        w_ill  = 1'b0;
        case (w_op)
            6'h00: begin
                w_dest = w_rd;
                case (w_funct)
                    6'h20: begin w_fun = FUN_ADD; w_sign = 1'b1; end
                    6'h21: w_fun = FUN_ADD;
                    6'h22: begin w_fun = FUN_SUB; w_sign = 1'b1; end
                    6'h23: w_fun = FUN_SUB;
                    6'h24: w_fun = FUN_AND;
                    6'h25: w_fun = FUN_OR;
                    6'h26: w_fun = FUN_XOR;
                    6'h27: w_fun = FUN_NOR;
                    6'h2A: begin w_fun = FUN_LT; w_sign = 1'b1; end
                    6'h2B: w_fun = FUN_LT;
                    6'h00: begin w_fun = FUN_SLL; w_a = w_shamt; end
                    6'h02: begin w_fun = FUN_SRL; w_a = w_shamt; end
                    6'h03: begin w_fun = FUN_SRA; w_a = w_shamt; end
                    6'h04: begin w_fun = FUN_SLL; w_a = {{(DATA_W-5){1'b0}}, rs_data[4:0]}; end
                    6'h06: begin w_fun = FUN_SRL; w_a = {{(DATA_W-5){1'b0}}, rs_data[4:0]}; end
                    6'h07: begin w_fun = FUN_SRA; w_a = {{(DATA_W-5){1'b0}}, rs_data[4:0]}; end
                    default: w_ill = 1'b1;
                endcase
            end
            6'h08: begin w_fun = FUN_ADD; w_sign = 1'b1; w_b = w_imm_sx; end
            6'h09: begin w_fun = FUN_ADD; w_b = w_imm_sx; end
            6'h0A: begin w_fun = FUN_LT;  w_sign = 1'b1; w_b = w_imm_sx; end
            6'h0B: begin w_fun = FUN_LT;  w_b = w_imm_sx; end
            6'h0C: begin w_fun = FUN_AND; w_b = w_imm_zx; end
            6'h0D: begin w_fun = FUN_OR;  w_b = w_imm_zx; end
            6'h0E: begin w_fun = FUN_XOR; w_b = w_imm_zx; end
            6'h0F: begin w_fun = FUN_SLL; w_a = DATA_W'(16); w_b = w_imm_zx; end
            6'h23: begin w_fun = FUN_ADD; w_b = w_imm_sx; end
            6'h2B: begin w_fun = FUN_ADD; w_b = w_imm_sx; w_wr = 1'b0; end
            6'h04: begin w_fun = FUN_EQ;  w_wr = 1'b0; end
            6'h05: begin w_fun = FUN_NEQ; w_wr = 1'b0; end
            // Compare-against-zero branches are signed tests of rs_data.
            6'h06: begin w_fun = FUN_LEZ; w_sign = 1'b1; w_b = '0; w_wr = 1'b0; end
            6'h07: begin w_fun = FUN_GTZ; w_sign = 1'b1; w_b = '0; w_wr = 1'b0; end
            6'h01: begin
                if (w_rt == 5'd0) begin
                    w_fun  = FUN_LTZ;
                    w_sign = 1'b1;
                    w_b    = '0;
                    w_wr   = 1'b0;
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_fun  = FUN_ADD;
            w_sign = 1'b0;
            w_a    = '0;
            w_b    = '0;
            w_dest = 5'd0;
            w_wr   = 1'b0;
        end
        if (ZERO_DEST_SQUASH && (w_dest == 5'd0)) w_wr = 1'b0;
    end

    // Handshake: an entry moves on any edge where its valid and ready are both high;
    // in_ready depends only on this stage's occupancy and out_ready, never on in_valid.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_fun   <= '0;
            r_sign  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_dest  <= '0;
            r_wr    <= 1'b0;
        end else begin
            if (flush)         r_valid <= 1'b0;
            else if (w_accept) r_valid <= 1'b1;
            else if (out_ready) r_valid <= 1'b0;
            if (w_accept) begin
                r_fun  <= w_fun;
                r_sign <= w_sign;
                r_a    <= w_a;
                r_b    <= w_b;
                r_dest <= w_dest;
                r_wr   <= w_wr;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_illegal <= 1'b0;
        else if (w_accept) r_illegal <= w_ill;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign out_valid = r_valid;
    assign alu_fun   = r_fun;
    assign alu_sign  = r_sign;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign dest      = r_dest;
    assign wr_en     = r_wr;
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID→EX issue stage that drives the ALU control/operand interface: alu_fun[5:0], alu_sign, alu_a, alu_b.
- Decodes a MIPS instruction word plus register-file read data into ALU controls and operands.
- Registers the result in a one-entry pipeline register with valid/ready handshake and flush.
- Sits between the register-file read stage and the ALU; its outputs feed the ALU directly.

Parameters:
- DATA_W, 32, operand width; only 32 supported.
- ZERO_DEST_SQUASH, 1, when 1 force wr_en=0 if dest==0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- rs_data  in  DATA_W  GPR[rs].
- rt_data  in  DATA_W  GPR[rt].
- flush  in  1  kill held and incoming entries.
- out_valid  out  1  issued entry present.
- out_ready  in  1  EX accepts.
- alu_fun  out  6  ALU function code.
- alu_sign  out  1  signed-compare/overflow select.
- alu_a  out  DATA_W  ALU operand A (shift amount in [4:0] for shifts).
- alu_b  out  DATA_W  ALU operand B.
- dest  out  5  writeback register.
- wr_en  out  1  result is written back.
- illegal  out  1  undecodable instruction (feature-dependent).

Behaviour:
- Reset: out_valid=0, alu_fun=0, alu_sign=0, alu_a=0, alu_b=0, dest=0, wr_en=0, illegal=0.
- in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready. Registers load on that edge, so latency is 1 cycle.
- out_valid next cycle = accept ? 1 : (out_valid && !out_ready ? 1 : 0).
- While out_valid && !out_ready, all outputs hold stable.
- flush: out_valid←0 on the next edge. An instruction accepted in the same cycle is discarded; flush wins.
- Data outputs may retain stale values when out_valid=0.
- ALU function codes (alu_fun):
  - ADD 000000, SUB 000001
  - AND 011000, OR 011110, XOR 010110, NOR 010001
  - SLL 100000, SRL 100001, SRA 100011
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111
- R-type (opcode 0). Default: alu_a=rs_data, alu_b=rt_data, dest=rd, wr_en=1.
  - add/sub: sign=1.
  - addu/subu: sign=0.
  - and, or, xor, nor.
  - slt→LT, sign=1; sltu→LT, sign=0.
  - sll/srl/sra: alu_a={27'b0,shamt}.
  - sllv/srlv/srav: alu_a={27'b0,rs_data[4:0]}.
- I-type. Default: alu_a=rs_data, dest=rt, wr_en=1.
  - addi, slti: sign=1, alu_b=sign-extended imm.
  - addiu, sltiu: sign=0, alu_b=sign-extended imm.
  - andi, ori, xori: zero-extended imm.
  - lui: SLL with alu_a=16, alu_b=zero-extended imm.
  - lw: ADD, sign-extended imm, wr_en=1.
  - sw: ADD, sign-extended imm, wr_en=0.
- Branches, all wr_en=0.
  - beq→EQ, bne→NEQ, both with alu_b=rt_data.
  - blez→LEZ, bgtz→GTZ, bltz (op 01, rt 0)→LTZ, all with alu_b=0.
- Any other opcode/funct is illegal. Issue as NOP: ADD, alu_a=alu_b=0, wr_en=0.
- ZERO_DEST_SQUASH=1: dest==0 forces wr_en=0.
- Reset asserted mid-stall drops the entry immediately (asynchronous).

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: illegal=1 is registered alongside the NOP entry, with out_valid=1.
- Undefined: illegal is tied 0 and illegal instructions issue as silent NOPs.

Test Plan:
- Add: instr 0x00221820, rs_data=5, rt_data=7, one accept → next cycle out_valid=1, alu_fun=000000, sign=1, a=5, b=7, dest=3, wr_en=1.
- Shift/lui:
  - 0x00021883 (sra $3,$2,2) → alu_fun=100011, a=2, b=rt_data.
  - 0x3C041234 (lui $4,0x1234) → alu_fun=100000, a=16, b=0x00001234, dest=4.
- Backpressure: issue entry, hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged. On release, second entry appears the following cycle and nothing is lost or duplicated.
- Flush: out_valid=1, out_ready=0, assert flush with in_valid=1 → next cycle out_valid=0. The new instruction never appears.
- Branch/store:
  - beq 0x10220003 → alu_fun=110011, b=rt_data, wr_en=0.
  - sw 0xAC220004 → ADD, b=4, wr_en=0.
  - addu $0 dest → wr_en=0.
- Illegal: opcode 0x3F. With macro: illegal=1, wr_en=0. Without macro: illegal=0, NOP issued. Also assert reset mid-stall → out_valid drops immediately.
